// File: rtl/game_timer_pkg.sv
// Shared types and two-digit BCD helpers for the game countdown timer.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Elaboration-time conversion of a 0..99 integer parameter into BCD.
    function automatic bcd2_t to_bcd2(input int v);
        bcd2_t r;
        r.tens = 4'((v / 10) % 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

    function automatic logic bcd2_gt(input bcd2_t a, input bcd2_t b);
        return (a.tens > b.tens) || ((a.tens == b.tens) && (a.ones > b.ones));
    endfunction

endpackage

// File: rtl/game_countdown_timer_bcd2_update.sv
// Combinational two-digit BCD step: optional decrement, then optional add clamped to a ceiling.
module bcd2_update
    import game_timer_pkg::*;
(
    input  logic [3:0] i_tens,
    input  logic [3:0] i_ones,
    input  logic       i_dec,
    input  logic       i_add_en,
    input  bcd2_t      i_add,
    input  bcd2_t      i_max,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_zero
);

    logic [3:0] w_dtens;
    logic [3:0] w_dones;
    logic [4:0] w_osum;
    logic [4:0] w_tsum;
    logic       w_carry;
    bcd2_t      w_sum;

    always_comb begin
        w_dtens = i_tens;
        w_dones = i_ones;
        // Decrement is suppressed at 00 so the value never wraps.
        if (i_dec && ((i_tens != 4'd0) || (i_ones != 4'd0))) begin
            if (i_ones == 4'd0) begin
                w_dones = 4'd9;
                w_dtens = i_tens - 4'd1;
            end else begin
                w_dones = i_ones - 4'd1;
            end
        end

        w_osum  = {1'b0, w_dones} + (i_add_en ? {1'b0, i_add.ones} : 5'd0);
        w_carry = (w_osum > 5'd9);
        w_tsum  = {1'b0, w_dtens} + (i_add_en ? {1'b0, i_add.tens} : 5'd0) + {4'd0, w_carry};

        w_sum.tens = w_tsum[3:0];
        w_sum.ones = w_carry ? 4'(w_osum - 5'd10) : w_osum[3:0];
        // A tens overflow past 9 is beyond any legal ceiling, so it clamps too.
        if ((w_tsum > 5'd9) || bcd2_gt(w_sum, i_max)) begin
            w_sum = i_max;
        end

        o_tens = w_sum.tens;
        o_ones = w_sum.ones;
        o_zero = (w_sum.tens == 4'd0) && (w_sum.ones == 4'd0);
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown in BCD seconds with pause, bonus time and a registered time-up pulse.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int START_SEC = 60,
    parameter int BONUS_SEC = 5,
    parameter int MAX_SEC   = 99,
    parameter int LOW_SEC   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       bonus,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       time_up,
    output logic       low_time
);

    localparam bcd2_t START_BCD = to_bcd2(START_SEC);
    localparam bcd2_t BONUS_BCD = to_bcd2(BONUS_SEC);
    localparam bcd2_t MAX_BCD   = to_bcd2(MAX_SEC);
    localparam bcd2_t LOW_BCD   = to_bcd2(LOW_SEC);

    state_t r_state;
    state_t w_nxt_state;
    bcd2_t  r_digits;
    bcd2_t  w_nxt_digits;
    bcd2_t  w_upd;
    logic   w_zero;
    logic   w_dec;
    logic   w_add_en;
    logic   r_running, r_expired, r_time_up, r_low_time;
    logic   w_nxt_running, w_nxt_expired, w_nxt_time_up, w_nxt_low_time;

    // Ticks only count in RUN without pause; bonus applies in RUN and PAUSE; start overrides both.
    assign w_dec    = (r_state == RUN) && !start && !pause && tick;
    assign w_add_en = ((r_state == RUN) || (r_state == PAUSE)) && !start && bonus;

    bcd2_update u_bcd2_update (
        .i_tens   (r_digits.tens),
        .i_ones   (r_digits.ones),
        .i_dec    (w_dec),
        .i_add_en (w_add_en),
        .i_add    (BONUS_BCD),
        .i_max    (MAX_BCD),
        .o_tens   (w_upd.tens),
        .o_ones   (w_upd.ones),
        .o_zero   (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_digits   <= START_BCD;
            r_running  <= 1'b0;
            r_expired  <= 1'b0;
            r_time_up  <= 1'b0;
            r_low_time <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_digits   <= w_nxt_digits;
            r_running  <= w_nxt_running;
            r_expired  <= w_nxt_expired;
            r_time_up  <= w_nxt_time_up;
            r_low_time <= w_nxt_low_time;
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_digits = r_digits;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nxt_state  = RUN;
                    w_nxt_digits = START_BCD;
                end
            end
            RUN: begin
                if (start) begin
                    w_nxt_digits = START_BCD;
                end else if (pause) begin
                    w_nxt_state  = PAUSE;
                    w_nxt_digits = w_upd;
                end else begin
                    w_nxt_digits = w_upd;
                    if (w_zero) begin
                        w_nxt_state = DONE;
                    end
                end
            end
            PAUSE: begin
                if (start) begin
                    w_nxt_state  = RUN;
                    w_nxt_digits = START_BCD;
                end else begin
                    w_nxt_digits = w_upd;
                    if (!pause) begin
                        w_nxt_state = RUN;
                    end
                end
            end
            DONE: begin
                w_nxt_digits = '0;
                if (start) begin
                    w_nxt_state  = RUN;
                    w_nxt_digits = START_BCD;
                end
            end
            default: begin
                w_nxt_state  = IDLE;
                w_nxt_digits = START_BCD;
            end
        endcase
    end

    always_comb begin
        w_nxt_running  = (w_nxt_state == RUN);
        w_nxt_expired  = (w_nxt_state == DONE);
        w_nxt_time_up  = (r_state == RUN) && (w_nxt_state == DONE);
        w_nxt_low_time = ((w_nxt_state == RUN) || (w_nxt_state == PAUSE)) &&
                         !bcd2_gt(w_nxt_digits, LOW_BCD);
    end

    assign sec_tens = r_digits.tens;
    assign sec_ones = r_digits.ones;
    assign running  = r_running;
    assign expired  = r_expired;
    assign time_up  = r_time_up;
    assign low_time = r_low_time;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with an integer reference model feeding a scoreboard queue.
module tb_game_countdown_timer;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       running;
        logic       expired;
        logic       time_up;
        logic       low_time;
    } obs_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tick  = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       bonus = 1'b0;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       expired;
    logic       time_up;
    logic       low_time;

    int   errors = 0;
    int   checks = 0;
    obs_t sb_q[$];

    // Reference model state: 0 idle, 1 run, 2 pause, 3 done; remaining seconds as an integer.
    int m_st  = 0;
    int m_rem = 60;

    game_countdown_timer #(
        .START_SEC (60),
        .BONUS_SEC (5),
        .MAX_SEC   (99),
        .LOW_SEC   (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .pause    (pause),
        .bonus    (bonus),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .expired  (expired),
        .time_up  (time_up),
        .low_time (low_time)
    );

    always #5 clk = ~clk;

    function automatic obs_t observed();
        obs_t o;
        o.tens     = sec_tens;
        o.ones     = sec_ones;
        o.running  = running;
        o.expired  = expired;
        o.time_up  = time_up;
        o.low_time = low_time;
        return o;
    endfunction

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic t, input logic s, input logic p, input logic b, output obs_t e);
        logic tu;
        tu = 1'b0;
        case (m_st)
            0: if (s) begin m_st = 1; m_rem = 60; end
            1: begin
                if (s) m_rem = 60;
                else if (p) begin
                    m_st = 2;
                    if (b) m_rem = sat(m_rem + 5);
                end else begin
                    m_rem = sat(m_rem - (t ? 1 : 0) + (b ? 5 : 0));
                    if (m_rem == 0) begin m_st = 3; tu = 1'b1; end
                end
            end
            2: begin
                if (s) begin m_st = 1; m_rem = 60; end
                else begin
                    if (b) m_rem = sat(m_rem + 5);
                    if (!p) m_st = 1;
                end
            end
            default: if (s) begin m_st = 1; m_rem = 60; end
        endcase
        e.tens     = 4'(m_rem / 10);
        e.ones     = 4'(m_rem % 10);
        e.running  = (m_st == 1);
        e.expired  = (m_st == 3);
        e.time_up  = tu;
        e.low_time = ((m_st == 1) || (m_st == 2)) && (m_rem <= 10);
    endtask

    task automatic step(input string tag, input logic t, input logic s, input logic p, input logic b);
        obs_t e;
        @(negedge clk);
        tick  = t;
        start = s;
        pause = p;
        bonus = b;
        model(t, s, p, b, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(tag, observed(), e);
        tick  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        bonus = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step("tick", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        obs_t rst_exp;
        rst_exp = '{tens: 4'd6, ones: 4'd0, running: 1'b0, expired: 1'b0, time_up: 1'b0, low_time: 1'b0};

        #12;
        check("reset_state", observed(), rst_exp);
        @(negedge clk);
        rst = 1'b0;

        step("idle_tick_ignored", 1'b1, 1'b0, 1'b0, 1'b0);
        step("idle_bonus_ignored", 1'b0, 1'b0, 1'b0, 1'b1);
        step("start", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        check8("digits_57", {sec_tens, sec_ones}, 8'h57);
        check8("run_flags_57", {4'd0, running, expired, time_up, low_time}, 8'h08);

        ticks(47);
        check8("digits_10", {sec_tens, sec_ones}, 8'h10);
        check8("low_at_10", {7'd0, low_time}, 8'h01);
        ticks(9);
        step("expire_tick", 1'b1, 1'b0, 1'b0, 1'b0);
        check8("expire_flags", {sec_tens, sec_ones}, 8'h00);
        check8("time_up_pulse", {4'd0, running, expired, time_up, low_time}, 8'h06);
        step("time_up_drops", 1'b0, 1'b0, 1'b0, 1'b0);
        check8("time_up_low", {7'd0, time_up}, 8'h00);
        step("done_tick_ignored", 1'b1, 1'b0, 1'b0, 1'b0);
        step("done_bonus_ignored", 1'b0, 1'b0, 1'b1, 1'b1);

        step("restart", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(18);
        check8("digits_42", {sec_tens, sec_ones}, 8'h42);
        step("pause_with_tick", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("paused_tick", 1'b1, 1'b0, 1'b1, 1'b0);
        check8("still_42", {sec_tens, sec_ones}, 8'h42);
        check8("paused_flags", {4'd0, running, expired, time_up, low_time}, 8'h00);
        step("unpause", 1'b0, 1'b0, 1'b0, 1'b0);
        step("resume_tick", 1'b1, 1'b0, 1'b0, 1'b0);
        check8("digits_41", {sec_tens, sec_ones}, 8'h41);

        ticks(4);
        for (int i = 0; i < 12; i++) step("bonus", 1'b0, 1'b0, 1'b0, 1'b1);
        check8("digits_97", {sec_tens, sec_ones}, 8'h97);
        step("bonus_saturate", 1'b0, 1'b0, 1'b0, 1'b1);
        check8("digits_99", {sec_tens, sec_ones}, 8'h99);
        step("pause_bonus_sat", 1'b1, 1'b0, 1'b1, 1'b1);
        step("unpause2", 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(98);
        check8("digits_01", {sec_tens, sec_ones}, 8'h01);
        step("tick_bonus_at_1", 1'b1, 1'b0, 1'b0, 1'b1);
        check8("digits_05", {sec_tens, sec_ones}, 8'h05);
        check8("no_time_up", {6'd0, expired, time_up}, 8'h00);

        step("restart2", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(30);
        step("borrow_30", 1'b1, 1'b0, 1'b0, 1'b0);
        check8("digits_29", {sec_tens, sec_ones}, 8'h29);
        ticks(19);
        step("borrow_10", 1'b1, 1'b0, 1'b0, 1'b0);
        check8("digits_09", {sec_tens, sec_ones}, 8'h09);
        check8("low_at_09", {7'd0, low_time}, 8'h01);
        ticks(9);
        step("start_from_done", 1'b0, 1'b1, 1'b0, 1'b0);
        check8("done_restart", {sec_tens, sec_ones, running, expired, 2'b00}, {8'h60, 1'b1, 1'b0, 2'b00});

        ticks(27);
        check8("digits_33", {sec_tens, sec_ones}, 8'h33);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_mid", observed(), rst_exp);
        m_st  = 0;
        m_rem = 60;
        @(posedge clk);
        #1;
        check("reset_held", observed(), rst_exp);
        @(negedge clk);
        rst = 1'b0;
        step("post_reset_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
Consumer end of the one-second enable tick used by the game timer. It loads a round duration and counts it down once per tick while the game is running, honouring pause. It adds bonus seconds on catch events and emits a registered time-up pulse for the game FSM. Outputs are two BCD digits that drive the seven-segment display mux directly.

Parameters:
START_SEC, 60, round length in seconds loaded on start (1..MAX_SEC)
BONUS_SEC, 5, seconds added per bonus pulse (0..MAX_SEC)
MAX_SEC, 99, saturation ceiling (<=99, fits two BCD digits)
LOW_SEC, 10, low-time warning threshold

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle one-second enable from the tick generator
start  in  1  one-cycle pulse: (re)load START_SEC and run
pause  in  1  level: freeze countdown while high
bonus  in  1  one-cycle pulse: add BONUS_SEC
sec_tens  out  4  BCD tens digit of remaining seconds
sec_ones  out  4  BCD ones digit of remaining seconds
running  out  1  high in RUN state
expired  out  1  high in DONE state
time_up  out  1  one-cycle pulse on expiry
low_time  out  1  high when remaining <= LOW_SEC and state is RUN or PAUSE

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk): state IDLE, digits = BCD(START_SEC), running=0, expired=0, time_up=0, low_time=0.
- Remaining time is held as two BCD digit registers. No binary counter. Every value is always valid BCD 00..MAX_SEC.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered and reflect the state and digits after the clock edge.
- IDLE: start -> RUN, digits=START_SEC. tick and bonus are ignored.
- RUN:
  - start has top priority: reload START_SEC, stay in RUN.
  - else pause=1 -> PAUSE. A tick in the same cycle is dropped. A bonus in the same cycle is applied.
  - else the value updates as follows: next = remaining - tick + bonus*BONUS_SEC, saturated at MAX_SEC.
  - If next == 0 -> DONE, and time_up=1 for exactly one cycle, aligned with expired rising.
  - tick and bonus together at remaining=1 gives BONUS_SEC, with no expiry when BONUS_SEC>0.
- PAUSE:
  - tick is ignored. bonus is applied with saturation.
  - start reloads START_SEC and goes to RUN.
  - pause=0 -> RUN, and the countdown resumes on the next tick.
- DONE: digits hold 00. tick, bonus and pause are ignored. start -> RUN with START_SEC.
- BCD decrement: ones borrow 0->9 with tens-1. Decrement never occurs at 00.
- BCD add: ones carry at >9. The result is clamped to MAX_SEC if it exceeds MAX_SEC (e.g. 97+5 -> 99).
- low_time is computed from the next-state digits, so it is valid in the same cycle as the displayed value.
- The tick input is a one-cycle pulse. A held-high tick decrements once per clk, and this is not filtered.
- Reset mid-round returns to IDLE immediately. No time_up is generated.

Decomposition:
- Package game_timer_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3)
  - a function to convert a parameter to a 2-digit BCD constant, used for START_SEC, BONUS_SEC, MAX_SEC and LOW_SEC
  - a 2-digit BCD compare function
- Sub-module bcd2_update is combinational. Inputs: tens, ones, dec, add_en, add value, max. Outputs: next tens and ones, and a zero flag. It isolates the digit arithmetic so it can be exhaustively tested (100 x 4 cases).
- The FSM and registers live in the top module.

Test Plan:
- Reset then start, apply 3 ticks -> digits 57, running=1, time_up=0, low_time=0.
- Start, then 50 ticks -> digits 10, low_time=1. Apply 10 more ticks -> 00, time_up high one cycle, expired=1, running=0. A further tick leaves 00.
- In RUN at 42, pause=1 with a coincident tick -> PAUSE, digits 42. Apply 5 ticks while paused -> 42. Drop pause, then 1 tick -> 41.
- At 97 apply bonus -> 99 (saturated). At 01, tick and bonus in the same cycle -> 05, no time_up.
- Borrow check: at 30, apply tick -> 29. At 10, apply tick -> 09 with low_time=1.
- In DONE apply start -> RUN with 60. Assert rst mid-round at 33 -> IDLE, digits 60, all flags 0, no time_up pulse.
